// File: rtl/custom_result_writer_if.sv
// Handshake/bus bundle between the top-level FSM, the result writer and the
// shared single-port RAM.
interface custom_result_writer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              en;
  logic [DATA_W-1:0] c11, c12, c21, c22;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              we_o;
  logic [DATA_W-1:0] data_i;
  logic              is_done_o;
  logic              err_o;

  modport master (
    output en, c11, c12, c21, c22, data_i,
    input  addr_o, data_o, we_o, is_done_o, err_o
  );

  modport slave (
    input  en, c11, c12, c21, c22, data_i,
    output addr_o, data_o, we_o, is_done_o, err_o
  );
endinterface

// File: rtl/custom_result_writer.sv
// Writes the four 2x2 result bytes to consecutive RAM addresses, optionally
// reads them back and raises a sticky mismatch flag.
module custom_result_writer #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 60,
  parameter int VERIFY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  custom_result_writer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t                 state_q;
  logic [1:0]             idx_q;
  logic [3:0][DATA_W-1:0] r_q;
  logic                   err_q;
  logic                   we_q;
  logic                   done_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      data_q;

  // Address arithmetic truncates to ADDR_W, so runs near the top wrap to 0.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] i);
    return BASE + ADDR_W'(i);
  endfunction

  // Outputs are registered alongside the state so nothing combinational
  // reaches the pins; each transition loads the values for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            r_q     <= {bus.c22, bus.c21, bus.c12, bus.c11};
            err_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= WRITE;
            we_q    <= 1'b1;
            addr_q  <= BASE;
            data_q  <= bus.c11;
          end
        end
        WRITE: begin
          if (idx_q == 2'd3) begin
            idx_q  <= '0;
            we_q   <= 1'b0;
            data_q <= '0;
            if (VERIFY != 0) begin
              state_q <= READ;
              addr_q  <= BASE;
            end else begin
              state_q <= DONE;
              addr_q  <= '0;
              done_q  <= 1'b1;
            end
          end else begin
            idx_q  <= idx_q + 2'd1;
            addr_q <= addr_of(idx_q + 2'd1);
            data_q <= r_q[idx_q + 2'd1];
          end
        end
        READ: begin
          // RAM data lags the address by one cycle: check the previous slot.
          if (idx_q != 2'd0 && bus.data_i != r_q[idx_q - 2'd1]) err_q <= 1'b1;
          if (idx_q == 2'd3) begin
            state_q <= CHECK;
          end else begin
            idx_q  <= idx_q + 2'd1;
            addr_q <= addr_of(idx_q + 2'd1);
          end
        end
        CHECK: begin
          if (bus.data_i != r_q[3]) err_q <= 1'b1;
          state_q <= DONE;
          idx_q   <= '0;
          addr_q  <= '0;
          done_q  <= 1'b1;
        end
        DONE: begin
          if (!bus.en) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr_o    = addr_q;
  assign bus.data_o    = data_q;
  assign bus.we_o      = we_q;
  assign bus.is_done_o = done_q;
  assign bus.err_o     = err_q;
endmodule

// File: tb/tb_custom_result_writer.sv
// Randomized bench for custom_result_writer: three instances (base 60 verify,
// base 62 verify, base 60 no-verify) checked against a timeline model.
module tb_custom_result_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic corrupt = 1'b0;
  logic chk_en = 1'b0;
  logic [7:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
  int checks = 0;
  int errors = 0;

  localparam int BASE [3] = '{60, 62, 60};
  localparam int VER  [3] = '{1, 1, 0};
  localparam int DCYC [3] = '{10, 10, 5};

  always #5 clk = ~clk;

  custom_result_writer_if #(.ADDR_W(6), .DATA_W(8)) if0 ();
  custom_result_writer_if #(.ADDR_W(6), .DATA_W(8)) if1 ();
  custom_result_writer_if #(.ADDR_W(6), .DATA_W(8)) if2 ();

  custom_result_writer #(.ADDR_W(6), .DATA_W(8), .BASE_ADDR(60), .VERIFY(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  custom_result_writer #(.ADDR_W(6), .DATA_W(8), .BASE_ADDR(62), .VERIFY(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  custom_result_writer #(.ADDR_W(6), .DATA_W(8), .BASE_ADDR(60), .VERIFY(0))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  logic [7:0] q [3];
  logic [7:0] mem [3][64];
  logic       we_s [3], done_s [3], err_s [3];
  logic [5:0] addr_s [3];
  logic [7:0] dat_s [3];

  assign if0.en = en; assign if0.c11 = c11; assign if0.c12 = c12;
  assign if0.c21 = c21; assign if0.c22 = c22; assign if0.data_i = q[0];
  assign if1.en = en; assign if1.c11 = c11; assign if1.c12 = c12;
  assign if1.c21 = c21; assign if1.c22 = c22; assign if1.data_i = q[1];
  assign if2.en = en; assign if2.c11 = c11; assign if2.c12 = c12;
  assign if2.c21 = c21; assign if2.c22 = c22; assign if2.data_i = q[2];

  assign we_s[0] = if0.we_o; assign addr_s[0] = if0.addr_o; assign dat_s[0] = if0.data_o;
  assign done_s[0] = if0.is_done_o; assign err_s[0] = if0.err_o;
  assign we_s[1] = if1.we_o; assign addr_s[1] = if1.addr_o; assign dat_s[1] = if1.data_o;
  assign done_s[1] = if1.is_done_o; assign err_s[1] = if1.err_o;
  assign we_s[2] = if2.we_o; assign addr_s[2] = if2.addr_o; assign dat_s[2] = if2.data_o;
  assign done_s[2] = if2.is_done_o; assign err_s[2] = if2.err_o;

  // Synchronous single-port RAMs; the corrupt switch spoils address 61 reads.
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      if (we_s[k]) mem[k][addr_s[k]] <= dat_s[k];
      q[k] <= (corrupt && addr_s[k] == 6'd61) ? 8'hFF : mem[k][addr_s[k]];
    end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int corrupt_slot(input int base);
    for (int j = 0; j < 4; j++) if ((base + j) % 64 == 61) return j;
    return -1;
  endfunction

  // Model: cycle n after the capture edge has cyc == n; 0 means idle.
  int         cyc [3];
  logic [7:0] r_m [3][4];
  logic       err_m [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        cyc[k] <= 0; err_m[k] <= 1'b0;
        for (int i = 0; i < 4; i++) r_m[k][i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cyc[k] == 0) begin
          if (en) begin
            cyc[k] <= 1; err_m[k] <= 1'b0;
            r_m[k][0] <= c11; r_m[k][1] <= c12; r_m[k][2] <= c21; r_m[k][3] <= c22;
          end
        end else if (cyc[k] < DCYC[k]) begin
          cyc[k] <= cyc[k] + 1;
          // readback of slot j is judged at the end of cycle 6+j
          if (VER[k] != 0 && corrupt && corrupt_slot(BASE[k]) >= 0 &&
              cyc[k] + 1 == 7 + corrupt_slot(BASE[k]) &&
              r_m[k][corrupt_slot(BASE[k])] != 8'hFF)
            err_m[k] <= 1'b1;
        end else if (!en) begin
          cyc[k] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int k = 0; k < 3; k++) begin
        int c, ea, ed;
        logic ew;
        c  = cyc[k];
        ew = (c >= 1 && c <= 4);
        ea = 0; ed = 0;
        if (ew) begin
          ea = (BASE[k] + c - 1) % 64; ed = r_m[k][c-1];
        end else if (VER[k] != 0 && c >= 5 && c <= 8) ea = (BASE[k] + c - 5) % 64;
        else if (VER[k] != 0 && c == 9) ea = (BASE[k] + 3) % 64;
        chk($sformatf("u%0d we c%0d", k, c), we_s[k], ew);
        chk($sformatf("u%0d addr c%0d", k, c), addr_s[k], ea);
        chk($sformatf("u%0d data c%0d", k, c), dat_s[k], ed);
        chk($sformatf("u%0d done c%0d", k, c), done_s[k], c == DCYC[k]);
        chk($sformatf("u%0d err c%0d", k, c), err_s[k], err_m[k]);
      end
    end
  end

  int first_done [3], we_cnt [3], done_cnt [3];

  // en high from the capture edge through cycle hold-1; c** scrambled after capture.
  task automatic run(input logic [7:0] a, b, c, d, input int hold);
    @(posedge clk); #2;
    c11 = a; c12 = b; c21 = c; c22 = d; en = 1'b1;
    for (int k = 0; k < 3; k++) begin first_done[k] = -1; we_cnt[k] = 0; done_cnt[k] = 0; end
    for (int n = 1; n <= hold + 14; n++) begin
      @(posedge clk); #2;
      en = (n < hold);
      c11 = 8'($urandom); c12 = 8'($urandom); c21 = 8'($urandom); c22 = 8'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_s[k] && first_done[k] < 0) first_done[k] = n;
        if (we_s[k]) we_cnt[k]++;
        if (done_s[k]) done_cnt[k]++;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    logic [7:0] old [4];
    logic [7:0] v [4];
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst u%0d we", k), we_s[k], 0);
      chk($sformatf("rst u%0d addr", k), addr_s[k], 0);
      chk($sformatf("rst u%0d data", k), dat_s[k], 0);
      chk($sformatf("rst u%0d done", k), done_s[k], 0);
      chk($sformatf("rst u%0d err", k), err_s[k], 0);
    end
    @(posedge clk); #2;
    rst = 1'b0; chk_en = 1'b1;

    // basic run with en held 5+ cycles past done
    run(8'h11, 8'h22, 8'h33, 8'h44, 16);
    chk("basic first done u0", first_done[0], 10);
    chk("basic first done u2", first_done[2], 5);
    chk("basic we cycles u0", we_cnt[0], 4);
    chk("basic we cycles u2", we_cnt[2], 4);
    chk("basic done cycles u0", done_cnt[0], 7);
    chk("basic ram60", mem[0][60], 8'h11);
    chk("basic ram61", mem[0][61], 8'h22);
    chk("basic ram62", mem[0][62], 8'h33);
    chk("basic ram63", mem[0][63], 8'h44);
    chk("basic ram63 noverify", mem[2][63], 8'h44);
    chk("basic err u0", err_s[0], 0);

    // wrap at base 62
    run(8'hA0, 8'hA1, 8'hA2, 8'hA3, 3);
    chk("wrap ram62", mem[1][62], 8'hA0);
    chk("wrap ram63", mem[1][63], 8'hA1);
    chk("wrap ram0", mem[1][0], 8'hA2);
    chk("wrap ram1", mem[1][1], 8'hA3);
    chk("wrap err", err_s[1], 0);

    // corrupted readback at address 61, then a clean run clears it
    corrupt = 1'b1;
    run(8'h01, 8'h02, 8'h03, 8'h04, 12);
    chk("mismatch err u0", err_s[0], 1);
    chk("mismatch err u1", err_s[1], 0);
    corrupt = 1'b0;
    run(8'h05, 8'h06, 8'h07, 8'h08, 12);
    chk("clean after mismatch err u0", err_s[0], 0);

    // single-cycle en pulse with c** churning afterwards
    run(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1);
    chk("pulse done cycles u0", done_cnt[0], 1);
    chk("pulse done cycles u2", done_cnt[2], 1);
    chk("pulse ram60", mem[0][60], 8'hC1);
    chk("pulse ram63", mem[0][63], 8'hC4);

    // reset during the second write cycle
    for (int i = 0; i < 4; i++) old[i] = mem[0][60+i];
    @(posedge clk); #2;
    c11 = 8'h5A; c12 = 8'h5B; c21 = 8'h5C; c22 = 8'h5D; en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst we u0", we_s[0], 0);
    chk("midrst we u1", we_s[1], 0);
    chk("midrst done u2", done_s[2], 0);
    #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst ram60", mem[0][60], 8'h5A);
    chk("midrst ram61", mem[0][61], old[1]);
    chk("midrst ram62", mem[0][62], old[2]);
    chk("midrst ram63", mem[0][63], old[3]);
    run(8'h71, 8'h72, 8'h73, 8'h74, 2);
    chk("post rst ram61", mem[0][61], 8'h72);
    chk("post rst first done", first_done[0], 10);

    // randomized runs
    for (int t = 0; t < 24; t++) begin
      corrupt = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
      run(v[0], v[1], v[2], v[3], int'($urandom_range(1, 14)));
      chk("rand ram60", mem[0][60], v[0]);
      chk("rand ram1 wrap", mem[1][1], v[3]);
      chk("rand we cycles u1", we_cnt[1], 4);
    end
    corrupt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
